// File: rtl/dmem_hs_if.sv
// Request/response bundle between the load/store unit (master) and dmem_hs (slave).
// Valid/ready request channel plus valid/ready response channel.
interface dmem_hs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_hs.sv
// Byte-addressable data memory with one-cycle valid/ready response, sub-word stores and extended loads.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag addresses above the array as errors.
module dmem_hs #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input logic      clk,
  input logic      rst,
  dmem_hs_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic [IW-1:0]     word_idx;
  logic [LB-1:0]     off;
  logic [3:0]        nbytes;
  logic              upper_nz, size_err, align_err, req_err;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh, rd_sh, keep, load_ext;
  logic              sign_bit;

  assign bus.req_ready = (state_q == EMPTY) | bus.rsp_ready;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept    = bus.req_valid & bus.req_ready;
  assign word_idx  = bus.req_addr[LB+IW-1:LB];
  assign off       = bus.req_addr[LB-1:0];
  assign nbytes    = 4'd1 << bus.req_size;
  assign size_err  = (DATA_W == 32) && (bus.req_size == 2'd3);
  assign align_err = ({{(4-LB){1'b0}}, off} & (nbytes - 4'd1)) != 4'd0;
  assign req_err   = size_err | align_err | (BOUNDS_EN & upper_nz);

  if (ADDR_W > LB + IW) begin : g_upper
    assign upper_nz = |bus.req_addr[ADDR_W-1:LB+IW];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Lane enables for the store and the keep-mask for the right-justified load.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign be[gi] = (gi >= int'(off)) && (gi < int'(off) + int'(nbytes));
    assign keep[gi*8 +: 8] = (gi < int'(nbytes)) ? 8'hFF : 8'h00;
  end

  assign wdata_sh = bus.req_wdata << {off, 3'b000};
  assign rd_sh    = mem_q[word_idx] >> {off, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    case (bus.req_size)
      2'd0:    sign_bit = rd_sh[7];
      2'd1:    sign_bit = rd_sh[15];
      2'd2:    sign_bit = rd_sh[31];
      default: sign_bit = rd_sh[DATA_W-1];
    endcase
    load_ext = (rd_sh & keep) | ((sign_bit & ~bus.req_unsigned) ? ~keep : '0);
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      err_d   = req_err;
      rdata_d = (req_err || bus.req_we) ? '0 : load_ext;
    end
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && bus.rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
    end else if (accept && bus.req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_hs;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int MEMB   = DEPTH * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  dmem_hs #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] mb [MEMB];

  function automatic void model_clear();
    for (int i = 0; i < MEMB; i++) mb[i] = 8'h00;
  endfunction

  // Little-endian byte array; an access covers bytes addr..addr+n-1.
  function automatic void model_access(input bit we, input logic [1:0] size, input bit uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] exp_rdata, output bit exp_err);
    int nb;
    int ea;
    logic [63:0] v;
    nb = 1 << size;
    exp_err = (size == 2'd3) || ((addr & 32'(nb - 1)) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (addr >= 32'(MEMB)) exp_err = 1'b1;
`endif
    exp_rdata = '0;
    if (exp_err) return;
    ea = int'(addr[7:0]);
    if (we) begin
      for (int i = 0; i < nb; i++) mb[ea+i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(mb[ea+i]) << (8*i));
      if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      exp_rdata = v[31:0];
    end
  endfunction

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output bit err, output bit got);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    got   = bus.rsp_valid;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> valid=%0b rdata=%h err=%0b",
             we, size, uns, addr, wdata, got, rdata, err);
  endtask

  task automatic test_reset();
    logic [31:0] rd, er;
    bit e, g, ee;
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, rd, e, g);
    model_access(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, er, ee);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL reset_pending: rsp_valid=%b want 1", bus.rsp_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL reset_async: rsp_valid=%b req_ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    n_checks++;
    if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0)
      $display("FAIL reset_rsp_regs: rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, e, g);
    n_checks++;
    if (g !== 1'b1 || rd !== 32'h0 || e !== 1'b0)
      $display("FAIL reset_load0: valid=%b rdata=%h err=%b want 1/00000000/0", g, rd, e);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, er;
    bit e, g, ee;
    logic [1:0]  l_size [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
    bit          l_uns  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] l_addr [4] = '{32'h8, 32'hA, 32'hA, 32'h8};
    logic [31:0] l_exp  [4] = '{32'hA180C3D4, 32'hFFFFFF80, 32'h00000080, 32'hFFFFC3D4};
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hA1B2C3D4, rd, e, g);
    model_access(1'b1, 2'd2, 1'b0, 32'h8, 32'hA1B2C3D4, er, ee);
    n_checks++;
    if (g !== 1'b1 || rd !== 32'h0 || e !== 1'b0)
      $display("FAIL lanes_store_word: valid=%b rdata=%h err=%b want 1/0/0", g, rd, e);
    else n_pass++;
    do_req(1'b1, 2'd0, 1'b0, 32'hA, 32'hFFFFFF80, rd, e, g);
    model_access(1'b1, 2'd0, 1'b0, 32'hA, 32'hFFFFFF80, er, ee);
    n_checks++;
    if (g !== 1'b1 || rd !== 32'h0 || e !== 1'b0)
      $display("FAIL lanes_store_byte: valid=%b rdata=%h err=%b want 1/0/0", g, rd, e);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, l_size[i], l_uns[i], l_addr[i], 32'h0, rd, e, g);
      model_access(1'b0, l_size[i], l_uns[i], l_addr[i], 32'h0, er, ee);
      n_checks++;
      if (g !== 1'b1 || rd !== l_exp[i] || e !== 1'b0)
        $display("FAIL lanes_load%0d: valid=%b rdata=%h err=%b want 1/%h/0", i, g, rd, e, l_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, er;
    bit e, g, ee;
    logic        m_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  m_size [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [31:0] m_addr [5] = '{32'h5, 32'h6, 32'h4, 32'h0, 32'h8};
    logic [31:0] m_wd   [5] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11111111};
    bit          m_err  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_req(m_we[i], m_size[i], 1'b0, m_addr[i], m_wd[i], rd, e, g);
      model_access(m_we[i], m_size[i], 1'b0, m_addr[i], m_wd[i], er, ee);
      n_checks++;
      if (g !== 1'b1 || rd !== 32'h0 || e !== m_err[i])
        $display("FAIL misalign%0d: valid=%b rdata=%h err=%b want 1/00000000/%b", i, g, rd, e, m_err[i]);
      else n_pass++;
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, e, g);
    model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, er, ee);
    n_checks++;
    if (g !== 1'b1 || rd !== 32'hA180C3D4 || e !== 1'b0)
      $display("FAIL misalign_no_write: rdata=%h err=%b want a180c3d4/0", rd, e);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1, exp2;
    bit ee;
    model_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, exp1, ee);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h8; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b1; bus.req_addr = 32'hA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp1 || bus.req_ready !== 1'b0)
        $display("FAIL bp_stall%0d: valid=%b rdata=%h req_ready=%b want 1/%h/0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp1);
      else n_pass++;
    end
    bus.rsp_ready = 1'b1;
    model_access(1'b0, 2'd0, 1'b1, 32'hA, 32'h0, exp2, ee);
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL bp_release: req_ready=%b want 1", bus.req_ready);
    else n_pass++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    $display("bp second response rdata=%h err=%0b", bus.rsp_rdata, bus.rsp_err);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp2 || bus.rsp_err !== 1'b0)
      $display("FAIL bp_second: valid=%b rdata=%h err=%b want 1/%h/0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, exp2);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL bp_drain: rsp_valid=%b want 0", bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_bounds();
    logic [31:0] rd, er, exp_rd;
    bit e, g, ee, exp_e;
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h5A5A0001, rd, e, g);
    model_access(1'b1, 2'd2, 1'b0, 32'h0, 32'h5A5A0001, er, ee);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, e, g);
    model_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, er, ee);
`ifdef DMEM_BOUNDS_CHECK_EN
    exp_rd = 32'h0;        exp_e = 1'b1;
`else
    exp_rd = 32'h5A5A0001; exp_e = 1'b0;
`endif
    n_checks++;
    if (g !== 1'b1 || rd !== exp_rd || e !== exp_e)
      $display("FAIL bounds_0x100: valid=%b rdata=%h err=%b want 1/%h/%b", g, rd, e, exp_rd, exp_e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_rd [$];
    bit          q_e  [$];
    logic [31:0] wd, er, xr;
    bit ee, xe, we;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) begin
        xr = q_rd.pop_front();
        xe = q_e.pop_front();
        $display("b2b rsp%0d rdata=%h err=%0b", j-1, bus.rsp_rdata, bus.rsp_err);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== xr || bus.rsp_err !== xe)
          $display("FAIL b2b_rsp%0d: valid=%b rdata=%h err=%b want 1/%h/%b",
                   j-1, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, xr, xe);
        else n_pass++;
      end
      if (j < 16) begin
        we = (j % 2 == 0);
        wd = $urandom;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'((j / 2) * 4); bus.req_wdata = wd; bus.rsp_ready = 1'b1;
        model_access(we, 2'd2, 1'b0, 32'((j / 2) * 4), wd, er, ee);
        q_rd.push_back(er);
        q_e.push_back(ee);
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready%0d: req_ready=%b want 1", j, bus.req_ready);
        else n_pass++;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_drain: rsp_valid=%b want 0", bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, er, addr, wd;
    logic [1:0]  size;
    bit e, g, ee, we, uns;
    int nb;
    for (int i = 0; i < 60; i++) begin
      size = 2'($urandom_range(0, 3));
      nb   = 1 << size;
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      do_req(we, size, uns, addr, wd, rd, e, g);
      model_access(we, size, uns, addr, wd, er, ee);
      n_checks++;
      if (g !== 1'b1 || rd !== er || e !== ee)
        $display("FAIL random%0d: valid=%b rdata=%h err=%b want 1/%h/%b", i, g, rd, e, er, ee);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_byte_lanes();
    test_misalign();
    test_backpressure();
    test_bounds();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
